// File: rtl/cacheline_element_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_element_unpacker_pkg
// Description : Shared constants, helper functions and request type for the
//               cacheline element unpacker and its lane selector.
// Revision    : 1.0 - initial release
// ============================================================================
package cacheline_element_unpacker_pkg;

    localparam int CACHELINE_SIZE_BITS = 1024;

    // Number of elements of a given width held in one line
    function automatic int element_num(input int elem_bits,
                                       input int line_bits = CACHELINE_SIZE_BITS);
        return line_bits / elem_bits;
    endfunction

    // One extra bit so that start/count values equal to N are representable
    function automatic int index_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Byte-reverse the low elem_bits of value; upper bits return zero
    function automatic logic [CACHELINE_SIZE_BITS-1:0] swap_endianness_element(
        input logic [CACHELINE_SIZE_BITS-1:0] value,
        input int                             elem_bits
    );
        logic [CACHELINE_SIZE_BITS-1:0] r;
        r = '0;
        for (int b = 0; b < CACHELINE_SIZE_BITS / 8; b++) begin
            if (b < elem_bits / 8) begin
                r[b*8 +: 8] = value[(elem_bits/8 - 1 - b)*8 +: 8];
            end
        end
        return r;
    endfunction

    // FSM encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_drain = 1'b1;

    localparam int c_default_index_bits = index_width(element_num(32, CACHELINE_SIZE_BITS));

    // Request as seen on the read-response side, default 32-bit elements
    typedef struct packed {
        logic [CACHELINE_SIZE_BITS-1:0]  data;
        logic [c_default_index_bits-1:0] start_index;
        logic [c_default_index_bits-1:0] count;
        logic [7:0]                      tag;
    } unpack_req_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_element_unpacker_lane_select.sv
`default_nettype none
// ============================================================================
// Module      : element_lane_select
// Description : Combinational lane picker. Lane k carries element idx+k of the
//               line (lane 0 in the most significant slot, same [0:n] order
//               as the line itself), optionally byte-swapped, zero when masked.
// Revision    : 1.0 - initial release
// ============================================================================
module element_lane_select #(
    parameter int CACHELINE_SIZE_BITS = 1024,
    parameter int ELEMENT_SIZE_BITS   = 32,
    parameter int LANES               = 1,
    parameter bit SWAP_ENDIAN         = 1'b1,
    parameter int IDX_BITS            = 6
) (
    input  logic [CACHELINE_SIZE_BITS-1:0]     i_line,
    input  logic [IDX_BITS-1:0]                i_idx,
    input  logic [IDX_BITS-1:0]                i_remaining,
    output logic [LANES*ELEMENT_SIZE_BITS-1:0] o_data,
    output logic [LANES-1:0]                   o_mask
);
    import cacheline_element_unpacker_pkg::*;

    localparam int c_n         = element_num(ELEMENT_SIZE_BITS, CACHELINE_SIZE_BITS);
    localparam int c_sel_bits  = $clog2(c_n);
    localparam int c_swap_bits = cacheline_element_unpacker_pkg::CACHELINE_SIZE_BITS;

    logic [ELEMENT_SIZE_BITS-1:0] w_elems [c_n];

    // Element i sits at the i-th slot counted from the MSB
    for (genvar gi = 0; gi < c_n; gi++) begin : g_elem
        assign w_elems[gi] = i_line[CACHELINE_SIZE_BITS-1-gi*ELEMENT_SIZE_BITS -: ELEMENT_SIZE_BITS];
    end

    for (genvar gk = 0; gk < LANES; gk++) begin : g_lane
        logic [IDX_BITS-1:0]          w_pos;
        logic                         w_valid;
        logic [ELEMENT_SIZE_BITS-1:0] w_raw;
        logic [ELEMENT_SIZE_BITS-1:0] w_out;

        // Position bound is redundant with count clamping but keeps the mux index in range
        assign w_pos   = i_idx + IDX_BITS'(gk);
        assign w_valid = (IDX_BITS'(gk) < i_remaining) && (w_pos < IDX_BITS'(c_n));
        assign w_raw   = w_elems[w_pos[c_sel_bits-1:0]];

        if (SWAP_ENDIAN) begin : g_swap
            assign w_out = ELEMENT_SIZE_BITS'(swap_endianness_element(c_swap_bits'(w_raw),
                                                                      ELEMENT_SIZE_BITS));
        end else begin : g_noswap
            assign w_out = w_raw;
        end

        assign o_mask[LANES-1-gk] = w_valid;
        assign o_data[(LANES-gk)*ELEMENT_SIZE_BITS-1 -: ELEMENT_SIZE_BITS] = w_valid ? w_out : '0;
    end

endmodule
`default_nettype wire

// File: rtl/cacheline_element_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_element_unpacker
// Description : Holds one cacheline and streams a trimmed run of its elements
//               out LANES at a time, with sideband tag and an emitted-element
//               statistics counter. Next line may load on the last handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_element_unpacker #(
    parameter int CACHELINE_SIZE_BITS = 1024,
    parameter int ELEMENT_SIZE_BITS   = 32,
    parameter int LANES               = 1,
    parameter bit SWAP_ENDIAN         = 1'b1,
    parameter int TAG_BITS            = 8,
    parameter int COUNT_BITS          = 32
) (
    input  logic                                                    clock,
    input  logic                                                    rst,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [CACHELINE_SIZE_BITS-1:0]                          in_data,
    input  logic [$clog2(CACHELINE_SIZE_BITS/ELEMENT_SIZE_BITS):0]  in_start_index,
    input  logic [$clog2(CACHELINE_SIZE_BITS/ELEMENT_SIZE_BITS):0]  in_count,
    input  logic [TAG_BITS-1:0]                                     in_tag,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [LANES*ELEMENT_SIZE_BITS-1:0]                      out_data,
    output logic [LANES-1:0]                                        out_mask,
    output logic                                                    out_last,
    output logic [TAG_BITS-1:0]                                     out_tag,
    output logic                                                    busy,
    output logic [COUNT_BITS-1:0]                                   elements_emitted
);
    import cacheline_element_unpacker_pkg::*;

    localparam int                    c_n         = element_num(ELEMENT_SIZE_BITS, CACHELINE_SIZE_BITS);
    localparam int                    c_idx_bits  = index_width(c_n);
    localparam logic [c_idx_bits-1:0] c_n_idx     = c_idx_bits'(c_n);
    localparam logic [c_idx_bits-1:0] c_lanes_idx = c_idx_bits'(LANES);

    logic [0:0]                       r_state;
    logic [0:0]                       w_state_next;
    logic [CACHELINE_SIZE_BITS-1:0]   r_line;
    logic [TAG_BITS-1:0]              r_tag;
    logic [c_idx_bits-1:0]            r_idx;
    logic [c_idx_bits-1:0]            r_rem;
    logic [COUNT_BITS-1:0]            r_count;
    logic [c_idx_bits-1:0]            w_eff;
    logic [c_idx_bits-1:0]            w_take;
    logic                             w_last;
    logic                             w_fire;
    logic                             w_load;
    logic [LANES*ELEMENT_SIZE_BITS-1:0] w_lane_data;
    logic [LANES-1:0]                 w_lane_mask;

    element_lane_select #(
        .CACHELINE_SIZE_BITS (CACHELINE_SIZE_BITS),
        .ELEMENT_SIZE_BITS   (ELEMENT_SIZE_BITS),
        .LANES               (LANES),
        .SWAP_ENDIAN         (SWAP_ENDIAN),
        .IDX_BITS            (c_idx_bits)
    ) u_lane_select (
        .i_line      (r_line),
        .i_idx       (r_idx),
        .i_remaining (r_rem),
        .o_data      (w_lane_data),
        .o_mask      (w_lane_mask)
    );

    // Effective count: clamp the request to the elements left in the line
    always_comb begin
        w_eff = '0;
        if (in_start_index < c_n_idx) begin
            if (in_count < (c_n_idx - in_start_index)) begin
                w_eff = in_count;
            end else begin
                w_eff = c_n_idx - in_start_index;
            end
        end
    end

    assign w_last = (r_rem <= c_lanes_idx);
    assign w_take = (r_rem < c_lanes_idx) ? r_rem : c_lanes_idx;
    assign w_fire = out_valid & out_ready;
    assign w_load = in_valid & in_ready & (w_eff != '0);

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a zero-length request never leaves IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_load) w_state_next = c_st_drain;
            end
            c_st_drain: begin
                if (out_ready && w_last) w_state_next = w_load ? c_st_drain : c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Outputs decoded from registered state only, except the in_ready pass-through
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        out_mask  = '0;
        in_ready  = 1'b1;
        if (r_state == c_st_drain) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = w_last;
            out_data  = w_lane_data;
            out_mask  = w_lane_mask;
            in_ready  = out_ready & w_last;
        end
    end

    assign out_tag          = r_tag;
    assign elements_emitted = r_count;

    // Line holding register and walk pointers; a load wins over the final advance
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_line <= '0;
            r_tag  <= '0;
            r_idx  <= '0;
            r_rem  <= '0;
        end else if (w_load) begin
            r_line <= in_data;
            r_tag  <= in_tag;
            r_idx  <= in_start_index;
            r_rem  <= w_eff;
        end else if (w_fire) begin
            r_idx  <= r_idx + c_lanes_idx;
            r_rem  <= r_rem - w_take;
        end
    end

    // Emitted-element counter; valid lanes per beat equal min(LANES, remaining)
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_fire) begin
            r_count <= r_count + COUNT_BITS'(w_take);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_element_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_element_unpacker
// Description : Directed self-checking bench, 32-bit elements, 4 lanes, swap on.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_element_unpacker;

    logic          clock;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_data;
    logic [5:0]    in_start_index;
    logic [5:0]    in_count;
    logic [7:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [3:0]    out_mask;
    logic          out_last;
    logic [7:0]    out_tag;
    logic          busy;
    logic [31:0]   elements_emitted;

    int n_vec = 0;
    int n_err = 0;

    cacheline_element_unpacker #(
        .CACHELINE_SIZE_BITS (1024),
        .ELEMENT_SIZE_BITS   (32),
        .LANES               (4),
        .SWAP_ENDIAN         (1'b1),
        .TAG_BITS            (8),
        .COUNT_BITS          (32)
    ) dut (
        .clock            (clock),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_start_index   (in_start_index),
        .in_count         (in_count),
        .in_tag           (in_tag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_mask         (out_mask),
        .out_last         (out_last),
        .out_tag          (out_tag),
        .busy             (busy),
        .elements_emitted (elements_emitted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Line whose element i (counted from the MSB) holds base+i
    function automatic logic [1023:0] mk_line(input logic [31:0] base);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[1023-32*i -: 32] = base + 32'(i);
        return r;
    endfunction

    // Expected beat: lane k (MSB first) = byte-swapped base+first+k for k < nv, else 0
    function automatic logic [127:0] exp_beat(input logic [31:0] base, input int first, input int nv);
        logic [127:0] r;
        logic [31:0]  v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < nv) begin
                v = base + 32'(first + k);
                r[127-32*k -: 32] = {v[7:0], v[15:8], v[23:16], v[31:24]};
            end
        end
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_start_index = '0;
        in_count = '0; in_tag = '0; out_ready = 1'b0;
        @(negedge clock); @(negedge clock);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (elements_emitted !== 32'd0) begin n_err++; $display("FAIL rst_counter: got %0d want 0", elements_emitted); end
        n_vec++; if (out_mask !== 4'b0000 || out_data !== 128'd0 || out_tag !== 8'd0)
            begin n_err++; $display("FAIL rst_outputs: got mask %b tag %h data %h want zeros", out_mask, out_tag, out_data); end
        rst = 1'b0;
        @(negedge clock);
        n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_idle: got in_ready %b busy %b want 1 0", in_ready, busy); end
    endtask

    task automatic test_full_line;
        @(negedge clock);
        in_data = mk_line(32'd0); in_start_index = 6'd0; in_count = 6'd32; in_tag = 8'hA5;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clock); in_valid = 1'b0; #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid beat %0d: got %b want 1", b, out_valid); end
            n_vec++; if (out_data !== exp_beat(32'd0, 4*b, 4)) begin n_err++; $display("FAIL full_data beat %0d: got %h want %h", b, out_data, exp_beat(32'd0, 4*b, 4)); end
            n_vec++; if (out_mask !== 4'b1111) begin n_err++; $display("FAIL full_mask beat %0d: got %b want 1111", b, out_mask); end
            n_vec++; if (out_last !== (b == 7)) begin n_err++; $display("FAIL full_last beat %0d: got %b want %b", b, out_last, (b == 7)); end
            n_vec++; if (out_tag !== 8'hA5) begin n_err++; $display("FAIL full_tag beat %0d: got %h want a5", b, out_tag); end
        end
        @(negedge clock); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_end_valid: got %b want 0", out_valid); end
        n_vec++; if (elements_emitted !== 32'd32) begin n_err++; $display("FAIL full_counter: got %0d want 32", elements_emitted); end
    endtask

    task automatic test_partial_line;
        @(negedge clock);
        in_data = mk_line(32'd0); in_start_index = 6'd30; in_count = 6'd10; in_tag = 8'h5A;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock); in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_err++; $display("FAIL part_valid_last: got %b %b want 1 1", out_valid, out_last); end
        n_vec++; if (out_data !== {32'h1E000000, 32'h1F000000, 64'd0}) begin n_err++; $display("FAIL part_data: got %h want %h", out_data, {32'h1E000000, 32'h1F000000, 64'd0}); end
        n_vec++; if (out_mask !== 4'b1100) begin n_err++; $display("FAIL part_mask: got %b want 1100", out_mask); end
        @(negedge clock); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL part_end_valid: got %b want 0", out_valid); end
        n_vec++; if (elements_emitted !== 32'd34) begin n_err++; $display("FAIL part_counter: got %0d want 34", elements_emitted); end
    endtask

    task automatic test_dropped_lines;
        logic [5:0] starts [2];
        logic [5:0] counts [2];
        starts[0] = 6'd5;  counts[0] = 6'd0;
        starts[1] = 6'd32; counts[1] = 6'd4;
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            in_data = mk_line(32'h300); in_start_index = starts[t]; in_count = counts[t];
            in_tag = 8'hEE; in_valid = 1'b1; out_ready = 1'b1; #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready case %0d: got %b want 1", t, in_ready); end
            @(negedge clock); in_valid = 1'b0; #1;
            n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL drop_valid case %0d: got %b busy %b want 0 0", t, out_valid, busy); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_after case %0d: got %b want 1", t, in_ready); end
            n_vec++; if (elements_emitted !== 32'd34) begin n_err++; $display("FAIL drop_counter case %0d: got %0d want 34", t, elements_emitted); end
        end
    endtask

    task automatic test_backpressure;
        logic pat [5];
        int   nb;
        int   transfers;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
        nb = 0; transfers = 0;
        @(negedge clock);
        in_data = mk_line(32'h100); in_start_index = 6'd0; in_count = 6'd12; in_tag = 8'h3C;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock); in_valid = 1'b0; out_ready = pat[c]; #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid cycle %0d: got %b want 1", c, out_valid); end
            n_vec++; if (out_data !== exp_beat(32'h100, 4*nb, 4) || out_mask !== 4'b1111)
                begin n_err++; $display("FAIL bp_data cycle %0d: got %h/%b want %h/1111", c, out_data, out_mask, exp_beat(32'h100, 4*nb, 4)); end
            n_vec++; if (out_tag !== 8'h3C || out_last !== (nb == 2))
                begin n_err++; $display("FAIL bp_tag_last cycle %0d: got %h %b want 3c %b", c, out_tag, out_last, (nb == 2)); end
            n_vec++; if (in_ready !== (pat[c] && nb == 2)) begin n_err++; $display("FAIL bp_in_ready cycle %0d: got %b want %b", c, in_ready, (pat[c] && nb == 2)); end
            if (out_valid && out_ready) transfers++;
            if (pat[c]) nb++;
        end
        @(negedge clock); out_ready = 1'b1; #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
        n_vec++; if (transfers != 3) begin n_err++; $display("FAIL bp_transfers: got %0d want 3", transfers); end
        n_vec++; if (elements_emitted !== 32'd46) begin n_err++; $display("FAIL bp_counter: got %0d want 46", elements_emitted); end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        in_data = mk_line(32'h1000); in_start_index = 6'd0; in_count = 6'd4; in_tag = 8'h11;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_data = mk_line(32'h2000); in_start_index = 6'd4; in_count = 6'd4; in_tag = 8'h22;
        in_valid = 1'b1; #1;
        n_vec++; if (out_valid !== 1'b1 || out_last !== 1'b1 || out_tag !== 8'h11)
            begin n_err++; $display("FAIL b2b_first: got v%b l%b tag %h want v1 l1 tag 11", out_valid, out_last, out_tag); end
        n_vec++; if (out_data !== exp_beat(32'h1000, 0, 4)) begin n_err++; $display("FAIL b2b_first_data: got %h want %h", out_data, exp_beat(32'h1000, 0, 4)); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(negedge clock); in_valid = 1'b0; #1;
        n_vec++; if (out_valid !== 1'b1 || out_last !== 1'b1 || out_tag !== 8'h22)
            begin n_err++; $display("FAIL b2b_second: got v%b l%b tag %h want v1 l1 tag 22", out_valid, out_last, out_tag); end
        n_vec++; if (out_data !== exp_beat(32'h2000, 4, 4) || out_mask !== 4'b1111)
            begin n_err++; $display("FAIL b2b_second_data: got %h/%b want %h/1111", out_data, out_mask, exp_beat(32'h2000, 4, 4)); end
        @(negedge clock); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
        n_vec++; if (elements_emitted !== 32'd54) begin n_err++; $display("FAIL b2b_counter: got %0d want 54", elements_emitted); end
    endtask

    task automatic test_reset_mid_line;
        @(negedge clock);
        in_data = mk_line(32'h40); in_start_index = 6'd0; in_count = 6'd32; in_tag = 8'h99;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clock); in_valid = 1'b0; #1;
            n_vec++; if (out_data !== exp_beat(32'h40, 4*b, 4)) begin n_err++; $display("FAIL mid_pre_data beat %0d: got %h want %h", b, out_data, exp_beat(32'h40, 4*b, 4)); end
        end
        @(negedge clock); #1;
        n_vec++; if (out_valid !== 1'b1 || elements_emitted !== 32'd62)
            begin n_err++; $display("FAIL mid_before_rst: got v%b count %0d want v1 count 62", out_valid, elements_emitted); end
        rst = 1'b1; #1;
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got v%b busy %b want 0 0", out_valid, busy); end
        n_vec++; if (elements_emitted !== 32'd0) begin n_err++; $display("FAIL mid_rst_counter: got %0d want 0", elements_emitted); end
        @(negedge clock);
        rst = 1'b0;
        in_data = mk_line(32'h500); in_start_index = 6'd8; in_count = 6'd8; in_tag = 8'h77;
        in_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clock); in_valid = 1'b0; #1;
            n_vec++; if (out_valid !== 1'b1 || out_tag !== 8'h77 || out_last !== (b == 1))
                begin n_err++; $display("FAIL mid_new_ctl beat %0d: got v%b tag %h l%b want v1 tag 77 l%b", b, out_valid, out_tag, out_last, (b == 1)); end
            n_vec++; if (out_data !== exp_beat(32'h500, 8 + 4*b, 4)) begin n_err++; $display("FAIL mid_new_data beat %0d: got %h want %h", b, out_data, exp_beat(32'h500, 8 + 4*b, 4)); end
        end
        @(negedge clock); #1;
        n_vec++; if (out_valid !== 1'b0 || elements_emitted !== 32'd8)
            begin n_err++; $display("FAIL mid_new_end: got v%b count %0d want v0 count 8", out_valid, elements_emitted); end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_partial_line();
        test_dropped_lines();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000 want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
